// File: rtl/fb_pkg.sv
// Shared constants and enumerations for the frame-buffer access arbiter.
// Default buffer geometry is 64K x RGB565, addressed as {row[7:0], col[7:0]}.
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } cap_state_t;

  typedef enum logic {
    MODE_LIVE = 1'b0,
    MODE_SNAP = 1'b1
  } cap_mode_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Write-holding FIFO for camera pixels waiting for a free buffer slot.
// Show-ahead output; push on full and pop on empty are ignored.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = store[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_50) begin
    if (push_ok) store[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer owner: VGA reads win, camera writes queue in a FIFO,
// with a starvation bound for writes and a per-frame capture sequencer.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int MEM_RD_LAT   = 1
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              capture_en,
  input  logic              snapshot,
  input  logic              frame_start,
  input  logic              frame_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        cap_state,
  output logic [7:0]        ovf_cnt
);

  localparam int                 STV_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0]   STARVE_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0]   STV_ONE    = STV_W'(1);
  localparam int                 ENT_W      = ADDR_W + DATA_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cap_state_t state_q;
  cap_mode_t  mode_q;

  logic             in_capture;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] fifo_dout;
  logic             wr_grant;
  logic             rd_grant;
  logic [STV_W-1:0] starve_cnt;
  logic [MEM_RD_LAT-1:0] rd_vld_pn;

  assign in_capture = (state_q == CAPTURE);
  assign cap_state  = state_q;

  // Outside CAPTURE the write port is a sink so the camera side never stalls.
  assign wr_ready  = in_capture ? !fifo_full : 1'b1;
  assign fifo_push = in_capture && wr_valid && !fifo_full;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .clk_50 (clk_50),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (wr_grant),
    .din    ({wr_addr, wr_data}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Reads own the port unless the queued writes have waited STARVE_LIMIT grants.
  assign wr_grant = !rst && !fifo_empty && (!rd_valid || (starve_cnt == STARVE_MAX));
  assign rd_grant = !rst && rd_valid && !wr_grant;
  assign rd_ready = rd_grant;

  always_comb begin
    mem_en    = wr_grant || rd_grant;
    mem_we    = wr_grant;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_grant) begin
      mem_addr  = fifo_dout[ENT_W-1:DATA_W];
      mem_wdata = fifo_dout[DATA_W-1:0];
    end else if (rd_grant) begin
      mem_addr  = rd_addr;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || wr_grant) begin
      starve_cnt <= '0;
    end else if (rd_grant) begin
      starve_cnt <= starve_cnt + STV_ONE;
    end
  end

  // Read-return stage: one valid bit per buffer latency cycle, in grant order.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      rd_vld_pn <= '0;
    end else begin
      rd_vld_pn <= (rd_vld_pn << 1) | MEM_RD_LAT'(rd_grant);
    end
  end

  // The buffer's output register is the data stage; only valid cycles pass it on.
  assign rd_data_valid = rd_vld_pn[MEM_RD_LAT-1];
  assign rd_data       = rd_data_valid ? mem_rdata : '0;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (wr_valid && !wr_ready) begin
      ovf_cnt <= sat_inc8(ovf_cnt);
    end
  end

  // frame_done is checked before frame_start so a coincident pair ends the frame.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_LIVE;
    end else begin
      case (state_q)
        IDLE: begin
          if (snapshot) begin
            state_q <= ARMED;
            mode_q  <= MODE_SNAP;
          end else if (capture_en) begin
            state_q <= ARMED;
            mode_q  <= MODE_LIVE;
          end
        end
        ARMED: begin
          if (frame_start) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (frame_done) begin
            if (mode_q == MODE_SNAP) state_q <= FROZEN;
            else if (capture_en)     state_q <= ARMED;
            else                     state_q <= IDLE;
          end
        end
        FROZEN: begin
          if (snapshot) begin
            state_q <= ARMED;
            mode_q  <= MODE_SNAP;
          end else if (capture_en) begin
            state_q <= ARMED;
            mode_q  <= MODE_LIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a registered-read buffer model.
module tb_fb_access_arbiter;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        capture_en, snapshot, frame_start, frame_done;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr, wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_addr;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  cap_state;
  logic [7:0]  ovf_cnt;

  logic [15:0] mem_arr [0:65535];
  logic [15:0] wlog_addr [$];
  logic [15:0] wlog_data [$];

  int tests = 0;
  int fails = 0;

  always #5 clk_50 = ~clk_50;

  fb_access_arbiter #(
    .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4), .STARVE_LIMIT(8), .MEM_RD_LAT(1)
  ) dut (
    .clk_50(clk_50), .rst(rst),
    .capture_en(capture_en), .snapshot(snapshot),
    .frame_start(frame_start), .frame_done(frame_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cap_state(cap_state), .ovf_cnt(ovf_cnt)
  );

  // Buffer model: one-cycle registered read, write on the grant edge.
  always @(posedge clk_50) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  always @(posedge clk_50) begin
    if (!rst && mem_en && mem_we) begin
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    capture_en = 0; snapshot = 0; frame_start = 0; frame_done = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0;
    repeat (2) @(posedge clk_50);
    #1;
    rst = 1'b0;
  endtask

  task automatic enter_capture_live();
    capture_en = 1; tick();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (cap_state !== 2'd0) begin fails++; $display("FAIL reset_cap_state got %0d want 0", cap_state); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    tests++; if (rd_ready !== 1'b0) begin fails++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
    tests++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_en got %b/%b want 0/0", mem_en, mem_we); end
    tests++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    tests++; if (rd_data_valid !== 1'b0 || rd_data !== 16'h0) begin fails++; $display("FAIL reset_rd_data got %b/%h want 0/0", rd_data_valid, rd_data); end
    tests++; if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_capture_write();
    int base;
    do_reset();
    capture_en = 1; tick();
    tests++; if (cap_state !== 2'd1) begin fails++; $display("FAIL cap_armed got %0d want 1", cap_state); end
    frame_start = 1; tick(); frame_start = 0;
    tests++; if (cap_state !== 2'd2) begin fails++; $display("FAIL cap_capture got %0d want 2", cap_state); end
    base = wlog_addr.size();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1; wr_addr = 16'h0300 + 16'(i); wr_data = 16'hA500 + 16'(i);
      #1;
      tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL cap_wr_ready beat %0d got %b want 1", i, wr_ready); end
      tick();
    end
    wr_valid = 0;
    repeat (3) tick();
    tests++; if (wlog_addr.size() - base !== 10) begin fails++; $display("FAIL cap_write_count got %0d want 10", wlog_addr.size() - base); end
    for (int i = 0; i < 10 && base + i < wlog_addr.size(); i++) begin
      tests++;
      if (wlog_addr[base+i] !== 16'h0300 + 16'(i) || wlog_data[base+i] !== 16'hA500 + 16'(i)) begin
        fails++;
        $display("FAIL cap_write_%0d got %h:%h want %h:%h", i, wlog_addr[base+i], wlog_data[base+i],
                 16'h0300 + 16'(i), 16'hA500 + 16'(i));
      end
    end
    capture_en = 0;
  endtask

  task automatic test_starvation();
    int   run;
    int   writes;
    logic prev_rdy;
    logic [15:0] prev_addr;
    do_reset();
    enter_capture_live();
    run = 0; writes = 0; prev_rdy = 0; prev_addr = '0;
    rd_valid = 1; wr_valid = 1;
    for (int c = 0; c < 45; c++) begin
      wr_addr = 16'h1000 + 16'(c); wr_data = 16'(c);
      rd_addr = 16'h2000 + 16'(c);
      #1;
      if (c > 0) begin
        tests++; if (rd_data_valid !== prev_rdy) begin fails++; $display("FAIL starve_rdv cycle %0d got %b want %b", c, rd_data_valid, prev_rdy); end
        if (prev_rdy) begin
          tests++; if (rd_data !== (prev_addr ^ 16'h5A5A)) begin fails++; $display("FAIL starve_rdata cycle %0d got %h want %h", c, rd_data, prev_addr ^ 16'h5A5A); end
        end
      end
      if (mem_en && mem_we) begin
        writes++;
        if (writes > 1) begin
          tests++; if (run !== 8) begin fails++; $display("FAIL starve_reads_between_writes got %0d want 8", run); end
        end
        run = 0;
      end else if (rd_ready) begin
        run++;
      end
      prev_rdy = rd_ready; prev_addr = rd_addr;
      tick();
    end
    tests++; if (writes !== 4) begin fails++; $display("FAIL starve_write_grants got %0d want 4", writes); end
    rd_valid = 0; wr_valid = 0; capture_en = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    enter_capture_live();
    rd_valid = 1; rd_addr = 16'h2100;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_addr = 16'h0400 + 16'(i); wr_data = 16'(i);
      #1;
      tests++; if (wr_ready !== (i < 4)) begin fails++; $display("FAIL ovf_wr_ready beat %0d got %b want %b", i, wr_ready, (i < 4)); end
      tick();
    end
    wr_valid = 0;
    tests++; if (ovf_cnt !== 8'd2) begin fails++; $display("FAIL ovf_two got %0d want 2", ovf_cnt); end
    wr_valid = 1;
    repeat (300) tick();
    wr_valid = 0;
    tests++; if (ovf_cnt !== 8'd255) begin fails++; $display("FAIL ovf_saturate got %0d want 255", ovf_cnt); end
    rd_valid = 0; capture_en = 0;
  endtask

  task automatic test_snapshot();
    int base;
    do_reset();
    snapshot = 1; tick(); snapshot = 0;
    tests++; if (cap_state !== 2'd1) begin fails++; $display("FAIL snap_armed got %0d want 1", cap_state); end
    frame_start = 1; tick(); frame_start = 0;
    tests++; if (cap_state !== 2'd2) begin fails++; $display("FAIL snap_capture got %0d want 2", cap_state); end
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 16'h0101 + 16'(i);
      wr_data = (i == 1) ? 16'hBEEF : 16'h1111 * 16'(i + 1);
      tick();
    end
    wr_valid = 0;
    frame_done = 1; tick(); frame_done = 0;
    tests++; if (cap_state !== 2'd3) begin fails++; $display("FAIL snap_frozen got %0d want 3", cap_state); end
    repeat (3) tick();
    base = wlog_addr.size();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 16'h0102; wr_data = 16'hDEAD;
      tick();
    end
    wr_valid = 0;
    repeat (2) tick();
    tests++; if (wlog_addr.size() - base !== 0) begin fails++; $display("FAIL snap_no_writes got %0d want 0", wlog_addr.size() - base); end
    rd_valid = 1; rd_addr = 16'h0102;
    #1;
    tests++; if (rd_ready !== 1'b1) begin fails++; $display("FAIL snap_rd_ready got %b want 1", rd_ready); end
    tick();
    rd_valid = 0;
    tests++; if (rd_data_valid !== 1'b1 || rd_data !== 16'hBEEF) begin fails++; $display("FAIL snap_read got %b:%h want 1:beef", rd_data_valid, rd_data); end
    tests++; if (cap_state !== 2'd3) begin fails++; $display("FAIL snap_still_frozen got %0d want 3", cap_state); end
  endtask

  task automatic test_live_drop();
    int base;
    do_reset();
    enter_capture_live();
    base = wlog_addr.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) capture_en = 0;
      wr_valid = 1; wr_addr = 16'h0500 + 16'(i); wr_data = 16'h7000 + 16'(i);
      tick();
    end
    wr_valid = 0;
    tests++; if (cap_state !== 2'd2) begin fails++; $display("FAIL live_drop_still_capture got %0d want 2", cap_state); end
    repeat (2) tick();
    tests++; if (wlog_addr.size() - base !== 6) begin fails++; $display("FAIL live_drop_writes got %0d want 6", wlog_addr.size() - base); end
    frame_done = 1; tick(); frame_done = 0;
    tests++; if (cap_state !== 2'd0) begin fails++; $display("FAIL live_drop_idle got %0d want 0", cap_state); end

    do_reset();
    enter_capture_live();
    frame_start = 1; frame_done = 1; tick(); frame_start = 0; frame_done = 0;
    tests++; if (cap_state !== 2'd1) begin fails++; $display("FAIL same_cycle_armed got %0d want 1", cap_state); end
    frame_start = 1; tick(); frame_start = 0;
    tests++; if (cap_state !== 2'd2) begin fails++; $display("FAIL rearm_capture got %0d want 2", cap_state); end
    capture_en = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    enter_capture_live();
    rd_valid = 1; rd_addr = 16'h2200;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_addr = 16'h0600 + 16'(i); wr_data = 16'(i);
      tick();
    end
    wr_valid = 0; rd_valid = 0;
    repeat (5) tick();
    tests++; if (ovf_cnt !== 8'd2) begin fails++; $display("FAIL mid_pre_ovf got %0d want 2", ovf_cnt); end
    rd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 16'h0700 + 16'(i); wr_data = 16'(i);
      tick();
    end
    wr_valid = 0;
    rst = 1'b1;
    #1;
    tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL mid_rst_mem_en got %b want 0", mem_en); end
    tests++; if (rd_data_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_rdv got %b want 0", rd_data_valid); end
    rd_valid = 0; capture_en = 0;
    tick(); tick();
    rst = 1'b0;
    base = wlog_addr.size();
    for (int c = 0; c < 6; c++) begin
      #1;
      tests++; if (mem_en !== 1'b0 || rd_data_valid !== 1'b0) begin fails++; $display("FAIL mid_after_rst cycle %0d got en=%b rdv=%b want 0/0", c, mem_en, rd_data_valid); end
      tick();
    end
    tests++; if (wlog_addr.size() - base !== 0) begin fails++; $display("FAIL mid_fifo_flushed got %0d writes want 0", wlog_addr.size() - base); end
    tests++; if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL mid_ovf got %0d want 0", ovf_cnt); end
    tests++; if (cap_state !== 2'd0) begin fails++; $display("FAIL mid_cap_state got %0d want 0", cap_state); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'(i) ^ 16'h5A5A;
    rst = 1'b1;
    capture_en = 0; snapshot = 0; frame_start = 0; frame_done = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0;
    test_reset();
    test_capture_write();
    test_starvation();
    test_overflow();
    test_snapshot();
    test_live_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
